// File: rtl/counter_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : counter_sweep_ctrl
// Purpose  : Steers an external up/down counter through N triangle sweeps
//            lo -> hi -> lo. Jobs arrive on a valid/ready command port.
// Revision : 1.0  initial release
// ============================================================================
module counter_sweep_ctrl #(
  parameter int W = 4,
  parameter int S = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_cmd_valid,
  output logic         o_cmd_ready,
  input  logic [W-1:0] i_cmd_lo,
  input  logic [W-1:0] i_cmd_hi,
  input  logic [S-1:0] i_cmd_sweeps,
  input  logic         i_abort,
  input  logic [W-1:0] i_count,
  output logic         o_up_down,
  output logic         o_cnt_clr,
  output logic         o_busy,
  output logic [S-1:0] o_sweep_cnt,
  output logic         o_done,
  output logic         o_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    RISE = 2'd2,
    FALL = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;

  logic [W-1:0] r_lo;
  logic [W-1:0] r_hi;
  logic [S-1:0] r_n;
  logic [S-1:0] r_sweep_cnt;
  logic         r_cnt_clr;
  logic         r_busy;
  logic         r_done;
  logic         r_err;

  logic         w_accept;
  logic         w_cmd_bad;
  logic         w_at_lo;
  logic         w_at_hi;
  logic [S-1:0] w_sweep_plus;
  logic         w_last_sweep;
  logic         w_up_down;
  logic         w_load;
  logic         w_sweep_inc;
  logic         w_done_nxt;
  logic         w_err_nxt;

  assign o_cmd_ready  = (r_state == IDLE) & ~i_abort;
  assign w_accept     = i_cmd_valid & o_cmd_ready;
  assign w_cmd_bad    = (i_cmd_lo >= i_cmd_hi) | (i_cmd_sweeps == '0);
  assign w_at_lo      = (i_count == r_lo);
  assign w_at_hi      = (i_count == r_hi);
  assign w_sweep_plus = r_sweep_cnt + {{(S-1){1'b0}}, 1'b1};
  assign w_last_sweep = (w_sweep_plus == r_n);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_up_down   = 1'b1;
    w_load      = 1'b0;
    w_sweep_inc = 1'b0;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_cmd_bad) begin
            w_err_nxt = 1'b1;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = SEEK;
          end
        end
      end
      SEEK: begin
        if (w_at_lo) begin
          w_state_nxt = RISE;
        end
      end
      RISE: begin
        if (w_at_hi) begin
          w_up_down   = 1'b0;
          w_state_nxt = FALL;
        end
      end
      FALL: begin
        // Turning up at lo also steps the counter to lo+1 on the final sweep;
        // the registered clear pulls it back to 0 a cycle later.
        if (w_at_lo) begin
          w_sweep_inc = 1'b1;
          if (w_last_sweep) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = RISE;
          end
        end else begin
          w_up_down = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    // Abort overrides any progress made on this edge; sweep_cnt is frozen.
    if (i_abort && (r_state != IDLE)) begin
      w_state_nxt = IDLE;
      w_sweep_inc = 1'b0;
      w_done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt_clr   <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_sweep_cnt <= '0;
      r_lo        <= '0;
      r_hi        <= '0;
      r_n         <= '0;
    end else begin
      r_cnt_clr <= (w_state_nxt == IDLE);
      r_busy    <= (w_state_nxt != IDLE);
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      if (w_load) begin
        r_lo        <= i_cmd_lo;
        r_hi        <= i_cmd_hi;
        r_n         <= i_cmd_sweeps;
        r_sweep_cnt <= '0;
      end else if (w_sweep_inc) begin
        r_sweep_cnt <= w_sweep_plus;
      end
    end
  end

  assign o_up_down   = w_up_down;
  assign o_cnt_clr   = r_cnt_clr;
  assign o_busy      = r_busy;
  assign o_sweep_cnt = r_sweep_cnt;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_counter_sweep_ctrl.sv
`default_nettype none
// tb_counter_sweep_ctrl: directed and randomized sweep jobs checked every cycle
// against a timeline model of the triangle sweep.
module tb_counter_sweep_ctrl;

  localparam int W = 4;
  localparam int S = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] cmd_lo = '0;
  logic [W-1:0] cmd_hi = '0;
  logic [S-1:0] cmd_sweeps = '0;
  logic [W-1:0] count = '0;
  logic         cmd_ready;
  logic         up_down;
  logic         cnt_clr;
  logic         busy;
  logic [S-1:0] sweep_cnt;
  logic         done;
  logic         err;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_on = 1'b0;

  // Model: a job is a timeline of edges k = 0 (accept) .. m_end (done).
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  bit m_err    = 1'b0;
  int m_k      = 0;
  int m_lo     = 0;
  int m_hi     = 1;
  int m_n      = 0;
  int m_end    = 0;
  int m_sweep  = 0;
  int m_count  = 0;

  int trace  [0:63];
  int strace [0:63];

  always #5 clk = ~clk;

  counter_sweep_ctrl #(.W(W), .S(S)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_lo     (cmd_lo),
    .i_cmd_hi     (cmd_hi),
    .i_cmd_sweeps (cmd_sweeps),
    .i_abort      (abort),
    .i_count      (count),
    .o_up_down    (up_down),
    .o_cnt_clr    (cnt_clr),
    .o_busy       (busy),
    .o_sweep_cnt  (sweep_cnt),
    .o_done       (done),
    .o_err        (err)
  );

  // The controlled up_down_counter, cleared synchronously by cnt_clr.
  always_ff @(posedge clk) begin
    count <= cnt_clr ? '0 : (up_down ? count + 1'b1 : count - 1'b1);
  end

  // Count value after edge k of the current job.
  function automatic int tri_pos(input int k);
    int d, p, len;
    if (k < m_lo) return k;
    len = m_hi - m_lo;
    d = k - m_lo;
    p = d % (2 * len);
    return (p <= len) ? (m_lo + p) : (m_lo + 2 * len - p);
  endfunction

  function automatic int sweeps_at(input int k);
    if (k < m_lo + 1) return 0;
    return (k - m_lo - 1) / (2 * (m_hi - m_lo));
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_edge();
    m_done = 1'b0;
    m_err  = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      m_sweep  = 0;
      m_count  = 0;
    end else if (!m_active) begin
      m_count = 0;
      if (cmd_valid && !abort) begin
        if ((cmd_lo >= cmd_hi) || (cmd_sweeps == 0)) begin
          m_err = 1'b1;
        end else begin
          m_active = 1'b1;
          m_k      = 0;
          m_lo     = int'(cmd_lo);
          m_hi     = int'(cmd_hi);
          m_n      = int'(cmd_sweeps);
          m_end    = m_lo + 1 + 2 * m_n * (m_hi - m_lo);
          m_sweep  = 0;
        end
      end
    end else begin
      m_count = tri_pos(m_k + 1);
      if (abort) begin
        m_active = 1'b0;
      end else begin
        m_k++;
        m_sweep = sweeps_at(m_k);
        if (m_k == m_end) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end
  endfunction

  function automatic void model_reset();
    m_active = 1'b0;
    m_done   = 1'b0;
    m_err    = 1'b0;
    m_sweep  = 0;
  endfunction

  initial begin
    bit e_ud;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        e_ud = m_active ? (tri_pos(m_k + 1) > tri_pos(m_k)) : 1'b1;
        check("busy",      32'(busy),      32'(m_active));
        check("cnt_clr",   32'(cnt_clr),   32'(!m_active));
        check("done",      32'(done),      32'(m_done));
        check("err",       32'(err),       32'(m_err));
        check("sweep_cnt", 32'(sweep_cnt), 32'(m_sweep));
        check("count",     32'(count),     32'(m_count));
        check("up_down",   32'(up_down),   32'(e_ud));
        check("cmd_ready", 32'(cmd_ready), 32'(!m_active && !abort));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic run_job(input int lo, input int hi, input int n, input bit rnd, output int done_k);
    cmd_valid  = 1'b1;
    cmd_lo     = W'(lo);
    cmd_hi     = W'(hi);
    cmd_sweeps = S'(n);
    abort      = 1'b0;
    tick();
    cmd_valid = 1'b0;
    trace[0]  = int'(count);
    strace[0] = int'(sweep_cnt);
    done_k    = -1;
    if (!busy) return;
    for (int k = 1; k <= 600; k++) begin
      if (rnd) begin
        abort      = ($urandom_range(0, 149) == 0);
        cmd_valid  = 1'($urandom_range(0, 1));
        cmd_lo     = W'($urandom);
        cmd_hi     = W'($urandom);
        cmd_sweeps = S'($urandom);
      end
      tick();
      if (k < 64) begin
        trace[k]  = int'(count);
        strace[k] = int'(sweep_cnt);
      end
      if (abort || done) begin
        done_k    = done ? k : -1;
        abort     = 1'b0;
        cmd_valid = 1'b0;
        return;
      end
    end
    check("job_timeout_busy", 32'(busy), 32'd0);
    cmd_valid = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic reject(input int lo, input int hi, input int n);
    cmd_valid  = 1'b1;
    cmd_lo     = W'(lo);
    cmd_hi     = W'(hi);
    cmd_sweeps = S'(n);
    tick();
    cmd_valid = 1'b0;
    check("reject_err", 32'(err), 32'd1);
    check("reject_busy", 32'(busy), 32'd0);
    tick();
    check("reject_err_clear", 32'(err), 32'd0);
  endtask

  initial begin
    int dk;
    int lo, hi, n, r;
    int exp_basic [0:14] = '{0, 1, 2, 3, 4, 5, 4, 3, 2, 3, 4, 5, 4, 3, 2};

    #1 rst = 1'b1;
    chk_on = 1'b1;
    tick();
    tick();
    check("reset_cnt_clr", 32'(cnt_clr), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_count", 32'(count), 32'd0);
    check("reset_sweep", 32'(sweep_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Basic job
    run_job(2, 5, 2, 1'b0, dk);
    check("basic_done_edge", 32'(dk), 32'd15);
    for (int k = 0; k < 15; k++) check("basic_trace", 32'(trace[k]), 32'(exp_basic[k]));
    check("basic_sweep_e9", 32'(strace[9]), 32'd1);
    check("basic_sweep_e15", 32'(strace[15]), 32'd2);
    tick();
    check("basic_count_cleared", 32'(count), 32'd0);

    // Full range, no wrap
    run_job(0, 15, 1, 1'b0, dk);
    check("full_done_edge", 32'(dk), 32'd31);
    check("full_peak", 32'(trace[15]), 32'd15);
    check("full_fall", 32'(trace[16]), 32'd14);
    check("full_bottom", 32'(trace[30]), 32'd0);
    tick();

    // Rejects
    reject(7, 7, 3);
    reject(9, 4, 3);
    reject(2, 5, 0);

    // Abort at E10, then a command with abort held
    cmd_valid = 1'b1; cmd_lo = 4'd1; cmd_hi = 4'd6; cmd_sweeps = 4'd3;
    tick();
    cmd_valid = 1'b0;
    for (int k = 1; k < 10; k++) tick();
    abort = 1'b1;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cnt_clr", 32'(cnt_clr), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    cmd_valid = 1'b1; cmd_lo = 4'd1; cmd_hi = 4'd6; cmd_sweeps = 4'd1;
    #1;
    check("abort_ready", 32'(cmd_ready), 32'd0);
    tick();
    check("abort_no_accept", 32'(busy), 32'd0);
    cmd_valid = 1'b0;
    abort = 1'b0;
    tick();

    // Reset mid-FALL
    cmd_valid = 1'b1; cmd_lo = 4'd2; cmd_hi = 4'd5; cmd_sweeps = 4'd3;
    tick();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 7; k++) tick();
    rst = 1'b1;
    model_reset();
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_cnt_clr", 32'(cnt_clr), 32'd1);
    check("midrst_sweep", 32'(sweep_cnt), 32'd0);
    check("midrst_up_down", 32'(up_down), 32'd1);
    tick();
    tick();
    check("midrst_count", 32'(count), 32'd0);
    rst = 1'b0;
    tick();
    run_job(0, 1, 1, 1'b0, dk);
    check("small_done_edge", 32'(dk), 32'd3);

    // Randomized jobs, including back-to-back commands
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0) begin
        abort = 1'b1; cmd_valid = 1'b1; cmd_lo = 4'd1; cmd_hi = 4'd3; cmd_sweeps = 4'd1;
        tick();
        abort = 1'b0; cmd_valid = 1'b0;
      end else if (r == 1) begin
        lo = $urandom_range(0, 15);
        hi = $urandom_range(0, lo);
        run_job(lo, hi, $urandom_range(0, 15), 1'b0, dk);
      end else begin
        lo = $urandom_range(0, 13);
        hi = $urandom_range(lo + 1, 15);
        n  = $urandom_range(1, 4);
        run_job(lo, hi, n, 1'b1, dk);
      end
    end
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/counter_sweep_ctrl.md
# counter_sweep_ctrl

Sequencer for the `up_down_counter` datapath. The counter has no enable; it moves by one on every `clk` edge in the direction given by `up_down`. This block drives that counter's `up_down` input and its reset (through `cnt_clr`) so the count performs N triangle sweeps between a programmed low bound and high bound. A new sweep job is accepted over a valid/ready command port. The block reports progress and completion, and the counter never wraps.

## Interface
- `W`, 4: counter width. Must match the counter instance.
- `S`, 4: width of the sweep-count fields.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `cmd_valid`  in  1: command request.
- `cmd_ready`  out  1: `IDLE & ~abort`.
- `cmd_lo`  in  W: low bound.
- `cmd_hi`  in  W: high bound.
- `cmd_sweeps`  in  S: number of sweeps N.
- `abort`  in  1: synchronous cancel.
- `count`  in  W: counter output, fed back to this block.
- `up_down`  out  1: combinational; drives the counter direction (1 = up).
- `cnt_clr`  out  1: registered; wired to the counter's reset.
- `busy`  out  1: registered; state != `IDLE`.
- `sweep_cnt`  out  S: registered; completed sweeps in the current job.
- `done`  out  1: registered one-cycle pulse.
- `err`  out  1: registered one-cycle pulse.

## Operation
- States: `IDLE`, `SEEK`, `RISE`, `FALL`. All decisions use `count` as sampled at the edge. `up_down` is the direction applied at that same edge.
- `IDLE`:
  - `cnt_clr`=1, which holds the counter at 0; `up_down`=1.
  - On an accepted command (`cmd_valid & cmd_ready`), check it first:
    - If `cmd_lo >= cmd_hi` or `cmd_sweeps == 0`: pulse `err`, stay in `IDLE`.
    - Otherwise: latch lo, hi and N; clear `sweep_cnt`; go to `SEEK`; `cnt_clr` drops to 0.
- `SEEK`: `up_down`=1. When `count == lo`, go to `RISE`.
- `RISE`:
  - `count != hi`: `up_down`=1.
  - `count == hi`: `up_down`=0, go to `FALL`.
- `FALL`:
  - `count != lo`: `up_down`=0.
  - `count == lo`: `up_down`=1 and `sweep_cnt`+1.
    - If this completes sweep N: go to `IDLE`, pulse `done`, set `cnt_clr`=1.
    - Otherwise: go to `RISE`.
- `abort` in a non-`IDLE` state:
  - Next state is `IDLE` and `cnt_clr`=1.
  - No `done` or `err` pulse.
  - `sweep_cnt` holds its value until the next accepted command.
- `abort` in `IDLE`: no effect, except that `cmd_ready` is 0 so no command is accepted that cycle.
- Turnaround happens at `hi` and `lo`, so `count` never wraps. `hi` = 2^W−1 is legal.
- Comparisons are unsigned, W bits.

## Timing
- Reset values: state `IDLE`, `cnt_clr`=1, `busy`=0, `sweep_cnt`=0, `done`=0, `err`=0. `up_down`=1 while in reset.
- `reset` asserted mid-job: immediate return to the reset values; the counter is cleared through `cnt_clr`.
- Command accept edge is E0. From E0:
  - `SEEK` takes lo+1 edges.
  - Each sweep then takes 2·(hi−lo) edges.
  - `done` is high for the one cycle after edge E(lo+1+2N(hi−lo)). `busy` falls at that same edge.
- The final `FALL` edge also steps the counter to lo+1. `cnt_clr` then forces it to 0 during the next cycle; this transient is allowed.
- `err` is high for the one cycle after the rejecting edge.
- `cmd_ready` is 0 from E0 until the cycle after `done` or abort.
- A back-to-back command may be accepted in the first `IDLE` cycle.

## Test plan
- **Reset:** assert `reset` for 2 cycles with `cmd_valid`=0 → `cnt_clr`=1, `busy`=0, `sweep_cnt`=0, `done`=0, `err`=0, `count` stays 0.
- **Basic job:** lo=2, hi=5, N=2 → `count` follows 0,1,2,3,4,5,4,3,2,3,4,5,4,3,2. `sweep_cnt` reads 1 then 2. `done` is high the cycle after E15. `count` is back to 0 one cycle later.
- **Full range:** lo=0, hi=15, N=1 → count rises 0..15 then falls to 0 with no wrap. `done` follows E31.
- **Rejects:** lo=7, hi=7, N=3 → `err` for one cycle, `busy` stays 0. Same result for lo=9, hi=4, and for N=0.
- **Abort:** lo=1, hi=6, N=3, with `abort` at E10 → `busy`=0 and `cnt_clr`=1 after E10, no `done`. A following command with `abort` held high is not accepted.
- **Reset mid-job:** assert `reset` mid-`FALL` → all outputs return to reset values asynchronously. After release, lo=0, hi=1, N=1 → `done` follows E3.
